fib_seq_gen: RTL and testbench
==============================

Name: fib_seq_gen

Overview:
Parametrised successor to the fixed 17-bit free-running Fibonacci counter. Generates a programmable-length additive sequence (t[n+2] = t[n] + t[n+1]) from two arbitrary seeds, so Fibonacci, Lucas and other sequences are all supported. Width and overflow policy are set by parameters. Terms leave on a valid/ready stream with an index, and start/busy/done control lets a sequencer or testbench drive one run at a time.

Parameters:
WIDTH, 17, bit width of seeds and terms
CNT_W, 8, width of num_terms and out_index
OVF_MODE, 0, overflow policy: 0 = STOP, 1 = WRAP, 2 = SATURATE

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a run; sampled only when state is IDLE
seed_a  input  WIDTH  term 0, sampled on accepted start
seed_b  input  WIDTH  term 1, sampled on accepted start
num_terms  input  CNT_W  number of terms to emit, sampled on accepted start
out_ready  input  1  consumer accepts the current term
out_valid  output  1  out/out_index hold a valid term
out  output  WIDTH  current term
out_index  output  CNT_W  index of current term, starting at 0
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse at end of run
overflow  output  1  sticky flag; cleared on the next accepted start

Behaviour:
- Reset values: state IDLE; out_valid=0, out=0, out_index=0, busy=0, done=0, overflow=0; internal a, b, remaining and ovf tags cleared. Reset takes effect from any state, mid-run included, and discards the run with no done pulse.
- FSM states: IDLE, RUN.
- Start, num_terms > 0:
  - Latch a=seed_a, b=seed_b, remaining=num_terms; clear overflow.
  - Next cycle: state RUN, busy=1, out_valid=1, out=seed_a, out_index=0. Start-to-first-valid latency is 1 cycle.
- Start, num_terms == 0: no term emitted; done pulses the next cycle; state stays IDLE.
- start asserted while in RUN is ignored.
- Handshake:
  - A transfer happens on the cycle where out_valid && out_ready.
  - While out_valid && !out_ready, out and out_index hold stable.
  - out_valid never drops without a transfer, except on reset.
- On a transfer that is not the last term:
  - out <= b; out_index += 1; a <= b; b <= a + b.
  - Adjacent transfers sustain 1 term per cycle.
- On a transfer of the last term (remaining == 1, or early stop):
  - Next cycle: out_valid=0, busy=0, done=1 for one cycle, state IDLE.
  - out and out_index keep their last values.
- Overflow detection:
  - Sum is computed at WIDTH+1 bits; the carry out tags the new b as overflowed.
  - overflow goes high on the cycle the tagged term would become out.
- Overflow by mode:
  - STOP (0): the tagged term is never emitted. The run ends after the current term is accepted: done pulses and overflow=1, even though remaining > 0.
  - WRAP (1): the tagged term is emitted truncated modulo 2^WIDTH; the run continues to num_terms.
  - SATURATE (2): the tagged term and all later terms are clamped to 2^WIDTH-1; the run continues to num_terms.
- done and out_valid are never high in the same cycle.
- A start in the cycle done is high is accepted, since state is already IDLE.

Optional Feature:
Macro FIB_SEQ_SUM_EN.
- Defined:
  - Adds output port out_sum, width WIDTH+CNT_W, reset 0.
  - Cleared on accepted start.
  - Accumulates the emitted out value on every transfer; the sum reflects the values as emitted after WRAP/SAT.
  - Valid and stable once done pulses; holds until the next start.
- Undefined: the port and accumulator do not exist; all other behaviour is identical.

Test Plan:
- Fibonacci run: seeds 0,1, num_terms 10, out_ready=1 → out 0,1,1,2,3,5,8,13,21,34 on 10 consecutive cycles at indices 0..9; done 1 cycle after the last transfer; overflow=0. With FIB_SEQ_SUM_EN, out_sum=88.
- Backpressure and Lucas seeds: seeds 2,1, num_terms 6; out_ready low for 3 cycles while index 3 is shown → out holds 4 for those cycles; full sequence 2,1,3,4,7,11; no term lost or duplicated.
- Overflow STOP (WIDTH=17, OVF_MODE=0): seeds 0,1, num_terms 40 → last emitted term is 121393 at index 26; done pulses; overflow=1; index 27 is never valid.
- Overflow WRAP and SAT with the same stimulus:
  - WRAP: index 27 = 65346 (196418 - 131072); overflow=1; 40 terms total.
  - SAT: index 27 onward = 131071; 40 terms total.
- Zero length and ignored start: num_terms 0 → done pulse, out_valid stays 0. Start pulsed during RUN of a 5-term run → sequence unchanged.
- Reset mid-run: reset at index 4 of a 10-term run → next cycle all outputs at reset values, no done pulse. A new start afterwards runs correctly from index 0.

Source files
------------

// File: rtl/fib_seq_gen.sv
// fib_seq_gen: programmable additive-sequence generator (t[n+2] = t[n] + t[n+1]).
//
// Emits num_terms terms, starting from two arbitrary seeds, on a valid/ready stream.
// Each term is tagged with its index. A run is started with start, which is only
// honoured in IDLE. busy is high for the whole run. done pulses for one cycle when
// the run ends.
//
// Parameters:
//   WIDTH    - bit width of seeds and terms
//   CNT_W    - width of num_terms and out_index
//   OVF_MODE - overflow policy: 0 = stop, 1 = wrap modulo 2^WIDTH, 2 = saturate
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin a run (sampled in IDLE only)
//   seed_a     in   term 0
//   seed_b     in   term 1
//   num_terms  in   number of terms to emit (0 = empty run, done only)
//   out_ready  in   consumer accepts the current term
//   out_valid  out  out/out_index hold a valid term
//   out        out  current term
//   out_index  out  index of the current term
//   busy       out  run in progress
//   done       out  one-cycle end-of-run pulse
//   overflow   out  sticky overflow flag, cleared by the next accepted start
//   out_sum    out  (FIB_SEQ_SUM_EN only) running sum of emitted terms
//
// Optional feature macro: FIB_SEQ_SUM_EN adds the out_sum accumulator and port.

module fib_seq_gen #(
  parameter int unsigned WIDTH    = 17,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned OVF_MODE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       seed_a,
  input  logic [WIDTH-1:0]       seed_b,
  input  logic [CNT_W-1:0]       num_terms,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out,
  output logic [CNT_W-1:0]       out_index,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
`ifdef FIB_SEQ_SUM_EN
  ,
  output logic [WIDTH+CNT_W-1:0] out_sum
`endif
);

  // Any mode value other than wrap or saturate behaves as stop.
  localparam bit IsWrap = (OVF_MODE == 1);
  localparam bit IsSat  = (OVF_MODE == 2);
  localparam bit IsStop = !IsWrap && !IsSat;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e state_q, state_d;

  // a_q is the term currently on out; b_q is the term that follows it.
  // The *_ovf tags mark a term whose generating sum carried out of WIDTH bits.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             a_ovf_q, a_ovf_d;
  logic             b_ovf_q, b_ovf_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] index_q, index_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;

  logic             start_ok;
  logic             start_run;
  logic             xfer;
  logic             stop_ovf;
  logic             last_xfer;
  logic [WIDTH:0]   sum_full;
  logic             carry;
  logic [WIDTH-1:0] next_b;
  logic             next_b_ovf;

  assign start_ok  = (state_q == StIdle) && start;
  assign start_run = start_ok && (num_terms != '0);
  assign xfer      = (state_q == StRun) && out_ready;
  // In stop mode a tagged successor ends the run after the current term.
  assign stop_ovf  = IsStop && b_ovf_q;
  assign last_xfer = xfer && ((remaining_q == CNT_W'(1)) || stop_ovf);

  assign sum_full  = {1'b0, a_q} + {1'b0, b_q};
  assign carry     = sum_full[WIDTH];

  // Saturation is sticky: once any operand was clamped, every later term is too.
  always_comb begin
    next_b     = sum_full[WIDTH-1:0];
    next_b_ovf = carry;
    if (IsSat && (carry || a_ovf_q || b_ovf_q)) begin
      next_b     = '1;
      next_b_ovf = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_run) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (last_xfer) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // out_valid tracks RUN exactly: RUN is entered with a term loaded and left on
  // the transfer of the last one, so done (registered) never overlaps it.
  always_comb begin
    busy      = (state_q == StRun);
    out_valid = (state_q == StRun);
  end

  assign out       = out_q;
  assign out_index = index_q;
  assign done      = done_q;
  assign overflow  = overflow_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    a_ovf_d     = a_ovf_q;
    b_ovf_d     = b_ovf_q;
    remaining_d = remaining_q;
    out_d       = out_q;
    index_d     = index_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;

    if (start_ok) begin
      a_d         = seed_a;
      b_d         = seed_b;
      a_ovf_d     = 1'b0;
      b_ovf_d     = 1'b0;
      remaining_d = num_terms;
      overflow_d  = 1'b0;
      if (num_terms != '0) begin
        out_d   = seed_a;
        index_d = '0;
      end else begin
        // Empty run: nothing to emit, just signal completion.
        done_d = 1'b1;
      end
    end else if (xfer) begin
      remaining_d = remaining_q - CNT_W'(1);
      if (last_xfer) begin
        // out/out_index keep the last emitted term.
        done_d = 1'b1;
        if (stop_ovf) begin
          overflow_d = 1'b1;
        end
      end else begin
        out_d   = b_q;
        index_d = index_q + CNT_W'(1);
        a_d     = b_q;
        a_ovf_d = b_ovf_q;
        b_d     = next_b;
        b_ovf_d = next_b_ovf;
        // Flag rises on the cycle the tagged term is presented.
        if (b_ovf_q) begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q         <= '0;
      b_q         <= '0;
      a_ovf_q     <= 1'b0;
      b_ovf_q     <= 1'b0;
      remaining_q <= '0;
      out_q       <= '0;
      index_q     <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      a_ovf_q     <= a_ovf_d;
      b_ovf_q     <= b_ovf_d;
      remaining_q <= remaining_d;
      out_q       <= out_d;
      index_q     <= index_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef FIB_SEQ_SUM_EN
  // ---------------------------------------------------------------------------
  // Optional accumulator of emitted terms (values as presented on out)
  // ---------------------------------------------------------------------------
  logic [WIDTH+CNT_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (start_ok) begin
      sum_d = '0;
    end else if (xfer) begin
      sum_d = sum_q + (WIDTH+CNT_W)'(out_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign out_sum = sum_q;
`endif

endmodule

// File: tb/tb_fib_seq_gen.sv
// Self-checking bench for fib_seq_gen. Three instances share stimulus and differ
// only in OVF_MODE (0 stop, 1 wrap, 2 saturate); instance 0 is the main observer.
// Inputs change on the falling edge, outputs are sampled on the falling edge.

module tb_fib_seq_gen;

  localparam int unsigned W  = 17;
  localparam int unsigned CW = 8;
  localparam longint unsigned MaxVal = 131071;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  seed_a;
  logic [W-1:0]  seed_b;
  logic [CW-1:0] num_terms;
  logic          out_ready;

  logic          v_valid[3];
  logic [W-1:0]  v_out[3];
  logic [CW-1:0] v_idx[3];
  logic          v_busy[3];
  logic          v_done[3];
  logic          v_ovf[3];
`ifdef FIB_SEQ_SUM_EN
  logic [W+CW-1:0] v_sum[3];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fib_seq_gen #(.WIDTH(W), .CNT_W(CW), .OVF_MODE(0)) u_stop (
    .clk(clk), .reset(reset), .start(start), .seed_a(seed_a), .seed_b(seed_b),
    .num_terms(num_terms), .out_ready(out_ready), .out_valid(v_valid[0]), .out(v_out[0]),
    .out_index(v_idx[0]), .busy(v_busy[0]), .done(v_done[0]), .overflow(v_ovf[0])
`ifdef FIB_SEQ_SUM_EN
    , .out_sum(v_sum[0])
`endif
  );

  fib_seq_gen #(.WIDTH(W), .CNT_W(CW), .OVF_MODE(1)) u_wrap (
    .clk(clk), .reset(reset), .start(start), .seed_a(seed_a), .seed_b(seed_b),
    .num_terms(num_terms), .out_ready(out_ready), .out_valid(v_valid[1]), .out(v_out[1]),
    .out_index(v_idx[1]), .busy(v_busy[1]), .done(v_done[1]), .overflow(v_ovf[1])
`ifdef FIB_SEQ_SUM_EN
    , .out_sum(v_sum[1])
`endif
  );

  fib_seq_gen #(.WIDTH(W), .CNT_W(CW), .OVF_MODE(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .seed_a(seed_a), .seed_b(seed_b),
    .num_terms(num_terms), .out_ready(out_ready), .out_valid(v_valid[2]), .out(v_out[2]),
    .out_index(v_idx[2]), .busy(v_busy[2]), .done(v_done[2]), .overflow(v_ovf[2])
`ifdef FIB_SEQ_SUM_EN
    , .out_sum(v_sum[2])
`endif
  );

  // Exact Fibonacci number (seeds 0,1), wide enough for the indices used here.
  function automatic longint unsigned fib(input int n);
    longint unsigned x = 0;
    longint unsigned y = 1;
    longint unsigned t;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    seed_a    = '0;
    seed_b    = '0;
    num_terms = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if ({v_valid[m], v_out[m], v_idx[m], v_busy[m], v_done[m], v_ovf[m]} !== 28'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got valid=%0b out=%0d idx=%0d busy=%0b done=%0b ovf=%0b, expected all 0",
                 m, v_valid[m], v_out[m], v_idx[m], v_busy[m], v_done[m], v_ovf[m]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fibonacci();
    int unsigned exp_t[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34};
    seed_a = 17'd0; seed_b = 17'd1; num_terms = 8'd10; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({v_valid[0], v_busy[0], v_out[0], v_idx[0]} !== {2'b11, W'(exp_t[i]), CW'(i)}) begin
        n_fail++;
        $display("FAIL fib term %0d: got valid=%0b busy=%0b out=%0d idx=%0d, expected out=%0d idx=%0d",
                 i, v_valid[0], v_busy[0], v_out[0], v_idx[0], exp_t[i], i);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({v_done[0], v_valid[0], v_busy[0], v_ovf[0], v_out[0], v_idx[0]} !==
        {4'b1000, W'(34), CW'(9)}) begin
      n_fail++;
      $display("FAIL fib end: got done=%0b valid=%0b busy=%0b ovf=%0b out=%0d idx=%0d, expected done=1 others 0 out=34 idx=9",
               v_done[0], v_valid[0], v_busy[0], v_ovf[0], v_out[0], v_idx[0]);
    end
`ifdef FIB_SEQ_SUM_EN
    n_checks++;
    if (v_sum[0] !== 25'd88) begin
      n_fail++;
      $display("FAIL fib sum: got %0d, expected 88", v_sum[0]);
    end
`endif
    @(negedge clk);
    n_checks++;
    if (v_done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL fib done pulse width: got done=%0b one cycle later, expected 0", v_done[0]);
    end
  endtask

  task automatic test_backpressure();
    int unsigned exp_t[6] = '{2, 1, 3, 4, 7, 11};
    int k = 0;
    int stall = 0;
    bit seen_done = 0;
    seed_a = 17'd2; seed_b = 17'd1; num_terms = 8'd6; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      if (v_done[0]) begin
        seen_done = 1;
      end else begin
        if (v_valid[0] && v_idx[0] == CW'(3) && stall < 3) begin
          out_ready = 1'b0;
          stall++;
          n_checks++;
          if ({v_out[0], v_idx[0]} !== {W'(4), CW'(3)}) begin
            n_fail++;
            $display("FAIL lucas hold %0d: got out=%0d idx=%0d, expected out=4 idx=3",
                     stall, v_out[0], v_idx[0]);
          end
        end else begin
          out_ready = 1'b1;
        end
        if (v_valid[0] && out_ready) begin
          n_checks++;
          if (k >= 6 || {v_out[0], v_idx[0]} !== {W'(exp_t[k]), CW'(k)}) begin
            n_fail++;
            $display("FAIL lucas term %0d: got out=%0d idx=%0d, expected out=%0d idx=%0d",
                     k, v_out[0], v_idx[0], (k < 6) ? exp_t[k] : 0, k);
          end
          k++;
        end
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    n_checks++;
    if (!seen_done || k != 6 || stall != 3 || v_ovf[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL lucas run: got done_seen=%0b terms=%0d stalls=%0d ovf=%0b, expected 1 6 3 0",
               seen_done, k, stall, v_ovf[0]);
    end
`ifdef FIB_SEQ_SUM_EN
    n_checks++;
    if (v_sum[0] !== 25'd28) begin
      n_fail++;
      $display("FAIL lucas sum: got %0d, expected 28", v_sum[0]);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int  cnt[3] = '{0, 0, 0};
    bit  fin[3] = '{0, 0, 0};
    int  exp_cnt[3] = '{27, 40, 40};
    longint unsigned f;
    longint unsigned e;
    seed_a = 17'd0; seed_b = 17'd1; num_terms = 8'd40; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 70 && !(fin[0] && fin[1] && fin[2]); c++) begin
      for (int m = 0; m < 3; m++) begin
        if (!fin[m]) begin
          if (v_done[m]) begin
            fin[m] = 1;
          end else if (v_valid[m]) begin
            f = fib(cnt[m]);
            e = (m == 1) ? (f % 131072) : ((f > MaxVal) ? MaxVal : f);
            n_checks++;
            if ({v_idx[m], v_out[m], v_ovf[m]} !== {CW'(cnt[m]), W'(e), (f > MaxVal)}) begin
              n_fail++;
              $display("FAIL ovf mode %0d term %0d: got idx=%0d out=%0d ovf=%0b, expected idx=%0d out=%0d ovf=%0b",
                       m, cnt[m], v_idx[m], v_out[m], v_ovf[m], cnt[m], e, (f > MaxVal));
            end
            cnt[m]++;
          end
        end
      end
      @(negedge clk);
    end
    for (int m = 0; m < 3; m++) begin
      n_checks++;
      if (!fin[m] || cnt[m] != exp_cnt[m] || v_ovf[m] !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf mode %0d run: got done_seen=%0b terms=%0d ovf=%0b, expected 1 %0d 1",
                 m, fin[m], cnt[m], v_ovf[m], exp_cnt[m]);
      end
    end
    n_checks++;
    if ({v_out[0], v_idx[0], v_valid[0]} !== {W'(121393), CW'(26), 1'b0}) begin
      n_fail++;
      $display("FAIL ovf stop last: got out=%0d idx=%0d valid=%0b, expected out=121393 idx=26 valid=0",
               v_out[0], v_idx[0], v_valid[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_and_ignored();
    int unsigned exp_t[5] = '{0, 1, 1, 2, 3};
    // Empty run; overflow left over from the previous run must clear.
    seed_a = 17'd9; seed_b = 17'd9; num_terms = 8'd0; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({v_done[0], v_valid[0], v_busy[0], v_ovf[0]} !== 4'b1000) begin
      n_fail++;
      $display("FAIL zero len: got done=%0b valid=%0b busy=%0b ovf=%0b, expected 1 0 0 0",
               v_done[0], v_valid[0], v_busy[0], v_ovf[0]);
    end
    @(negedge clk);
    n_checks++;
    if ({v_done[0], v_valid[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero len after: got done=%0b valid=%0b, expected 0 0", v_done[0], v_valid[0]);
    end
    seed_a = 17'd0; seed_b = 17'd1; num_terms = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({v_valid[0], v_out[0], v_idx[0]} !== {1'b1, W'(exp_t[i]), CW'(i)}) begin
        n_fail++;
        $display("FAIL ignored start term %0d: got valid=%0b out=%0d idx=%0d, expected out=%0d idx=%0d",
                 i, v_valid[0], v_out[0], v_idx[0], exp_t[i], i);
      end
      if (i == 2) begin
        seed_a = 17'd7; seed_b = 17'd7; num_terms = 8'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if ({v_done[0], v_valid[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL ignored start end: got done=%0b valid=%0b, expected 1 0", v_done[0], v_valid[0]);
    end
    @(negedge clk);
    n_checks++;
    if (v_valid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored start relaunch: got valid=%0b, expected 0", v_valid[0]);
    end
  endtask

  task automatic test_reset_midrun();
    int unsigned exp_t[5] = '{0, 1, 1, 2, 3};
    bit bad_done = 0;
    seed_a = 17'd0; seed_b = 17'd1; num_terms = 8'd10; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({v_valid[0], v_out[0], v_idx[0]} !== {1'b1, W'(exp_t[i]), CW'(i)}) begin
        n_fail++;
        $display("FAIL midrun term %0d: got valid=%0b out=%0d idx=%0d, expected out=%0d idx=%0d",
                 i, v_valid[0], v_out[0], v_idx[0], exp_t[i], i);
      end
      if (i == 4) reset = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if ({v_valid[0], v_out[0], v_idx[0], v_busy[0], v_done[0], v_ovf[0]} !== 28'd0) begin
      n_fail++;
      $display("FAIL midrun reset: got valid=%0b out=%0d idx=%0d busy=%0b done=%0b ovf=%0b, expected all 0",
               v_valid[0], v_out[0], v_idx[0], v_busy[0], v_done[0], v_ovf[0]);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (v_done[0] || v_valid[0]) bad_done = 1;
    end
    n_checks++;
    if (bad_done) begin
      n_fail++;
      $display("FAIL midrun after reset: got a done or valid after reset, expected none");
    end
  endtask

  task automatic test_back_to_back();
    int unsigned exp_t[3] = '{0, 1, 1};
    seed_a = 17'd0; seed_b = 17'd1; num_terms = 8'd3; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({v_valid[0], v_out[0], v_idx[0]} !== {1'b1, W'(exp_t[i]), CW'(i)}) begin
        n_fail++;
        $display("FAIL b2b term %0d: got valid=%0b out=%0d idx=%0d, expected out=%0d idx=%0d",
                 i, v_valid[0], v_out[0], v_idx[0], exp_t[i], i);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({v_done[0], v_valid[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b done: got done=%0b valid=%0b, expected 1 0", v_done[0], v_valid[0]);
    end
    // Start during the done cycle must be accepted.
    seed_a = 17'd2; seed_b = 17'd1; num_terms = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({v_valid[0], v_out[0], v_idx[0]} !== {1'b1, W'(2), CW'(0)}) begin
      n_fail++;
      $display("FAIL b2b restart t0: got valid=%0b out=%0d idx=%0d, expected 1 2 0",
               v_valid[0], v_out[0], v_idx[0]);
    end
    @(negedge clk);
    n_checks++;
    if ({v_valid[0], v_out[0], v_idx[0]} !== {1'b1, W'(1), CW'(1)}) begin
      n_fail++;
      $display("FAIL b2b restart t1: got valid=%0b out=%0d idx=%0d, expected 1 1 1",
               v_valid[0], v_out[0], v_idx[0]);
    end
    @(negedge clk);
    n_checks++;
    if ({v_done[0], v_valid[0]} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b restart done: got done=%0b valid=%0b, expected 1 0", v_done[0], v_valid[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fibonacci();
    test_backpressure();
    test_overflow();
    test_zero_and_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
